// File: rtl/bt_cmd_rx_if.sv
// Bluetooth command receiver bus: serial line in, received byte and decoded command strobes out.
// master = receiver side, slave = consumer side.
interface bt_cmd_rx_if #(
   parameter int unsigned TRACK_W = 4,
   parameter int unsigned VOL_W   = 4
);
   logic               UART_RXD;
   logic [7:0]         RXD_DATA;
   logic               RXD_VALID;
   logic               FRAME_ERR;
   logic               PREV;
   logic               NEXT;
   logic               UP;
   logic               DOWN;
   logic               JUMP;
   logic [TRACK_W-1:0] JUMP_TRACK;
   logic [VOL_W-1:0]   VOLUME;
   logic               CMD_ERR;

   modport master (
      input  UART_RXD,
      output RXD_DATA, RXD_VALID, FRAME_ERR, PREV, NEXT, UP, DOWN,
             JUMP, JUMP_TRACK, VOLUME, CMD_ERR
   );

   modport slave (
      output UART_RXD,
      input  RXD_DATA, RXD_VALID, FRAME_ERR, PREV, NEXT, UP, DOWN,
             JUMP, JUMP_TRACK, VOLUME, CMD_ERR
   );
endinterface

// File: rtl/bt_cmd_rx.sv
// 16x-oversampled UART receiver feeding a byte-framed command decoder that emits
// single-cycle transport/volume/jump strobes and keeps a saturating volume register.
module bt_cmd_rx #(
   parameter int unsigned CLK_HZ      = 100000000,
   parameter int unsigned BAUD        = 9600,
   parameter int unsigned NUM_TRACKS  = 8,
   parameter int unsigned TRACK_W     = 4,
   parameter int unsigned VOL_W       = 4,
   parameter int unsigned VOL_MAX     = 15,
   parameter int unsigned VOL_RST     = 8,
   parameter int unsigned TIMEOUT_CYC = 1000000
) (
   input  logic        CLK,
   input  logic        RST,
   bt_cmd_rx_if.master bus
);
   localparam int unsigned DIV   = CLK_HZ / (BAUD * 16);
   localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned TO_W  = $clog2(TIMEOUT_CYC + 1);

   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
   localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYC - 1);
   localparam logic [VOL_W-1:0] VOL_MAX_V = VOL_W'(VOL_MAX);
   localparam logic [VOL_W-1:0] VOL_RST_V = VOL_W'(VOL_RST);
   localparam logic [7:0]       VOL_MAX_B = 8'(VOL_MAX);
   localparam logic [3:0]       NTRK      = 4'(NUM_TRACKS);

   typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
   typedef enum logic       {D_IDLE, D_ARG} dec_state_t;

   // ---------------- receiver ----------------
   logic             rxd_meta, rxd_sync;
   logic [DIV_W-1:0] div_cnt;
   logic             tick, div_clr;
   rx_state_t        rx_state, rx_state_n;
   logic [3:0]       tick_cnt, tick_cnt_n;
   logic [2:0]       bit_cnt, bit_cnt_n;
   logic [7:0]       shift_q, shift_n;
   logic [7:0]       rxd_data_q, rxd_data_n;
   logic             rxd_valid_q, rxd_valid_n;
   logic             frame_err_q, frame_err_n;

   always_ff @(posedge CLK) begin
      if (RST) begin
         rxd_meta <= 1'b1;
         rxd_sync <= 1'b1;
      end else begin
         rxd_meta <= bus.UART_RXD;
         rxd_sync <= rxd_meta;
      end
   end

   // Divider restarts on a start edge so ticks stay phase-aligned to the frame
   always_ff @(posedge CLK) begin
      if (RST || div_clr || div_cnt == DIV_LAST) div_cnt <= '0;
      else                                       div_cnt <= div_cnt + DIV_W'(1);
   end
   assign tick = (div_cnt == DIV_LAST);

   always_ff @(posedge CLK) begin
      if (RST) begin
         rx_state    <= R_IDLE;
         tick_cnt    <= '0;
         bit_cnt     <= '0;
         shift_q     <= '0;
         rxd_data_q  <= '0;
         rxd_valid_q <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         rx_state    <= rx_state_n;
         tick_cnt    <= tick_cnt_n;
         bit_cnt     <= bit_cnt_n;
         shift_q     <= shift_n;
         rxd_data_q  <= rxd_data_n;
         rxd_valid_q <= rxd_valid_n;
         frame_err_q <= frame_err_n;
      end
   end

   always_comb begin
      rx_state_n  = rx_state;
      tick_cnt_n  = tick_cnt;
      bit_cnt_n   = bit_cnt;
      shift_n     = shift_q;
      rxd_data_n  = rxd_data_q;
      rxd_valid_n = 1'b0;
      frame_err_n = 1'b0;
      div_clr     = 1'b0;
      case (rx_state)
         R_IDLE: begin
            if (!rxd_sync) begin
               rx_state_n = R_START;
               tick_cnt_n = '0;
               div_clr    = 1'b1;
            end
         end
         R_START: begin
            if (tick) begin
               if (tick_cnt == 4'd7) begin
                  tick_cnt_n = '0;
                  bit_cnt_n  = '0;
                  rx_state_n = rxd_sync ? R_IDLE : R_DATA;
               end else begin
                  tick_cnt_n = tick_cnt + 4'd1;
               end
            end
         end
         R_DATA: begin
            if (tick) begin
               tick_cnt_n = tick_cnt + 4'd1;
               if (tick_cnt == 4'd15) begin
                  shift_n   = {rxd_sync, shift_q[7:1]};
                  bit_cnt_n = bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) rx_state_n = R_STOP;
               end
            end
         end
         R_STOP: begin
            if (tick) begin
               tick_cnt_n = tick_cnt + 4'd1;
               if (tick_cnt == 4'd15) begin
                  rx_state_n = R_IDLE;
                  if (rxd_sync) begin
                     rxd_data_n  = shift_q;
                     rxd_valid_n = 1'b1;
                  end else begin
                     frame_err_n = 1'b1;
                  end
               end
            end
         end
         default: rx_state_n = R_IDLE;
      endcase
   end

   // ---------------- decoder ----------------
   dec_state_t         dec_state, dec_state_n;
   logic [TO_W-1:0]    to_cnt, to_cnt_n;
   logic [VOL_W-1:0]   vol_q, vol_n;
   logic [TRACK_W-1:0] jtrack_q, jtrack_n;
   logic prev_q, next_q, up_q, down_q, jump_q, err_q;
   logic prev_n, next_n, up_n, down_n, jump_n, err_n;

   always_ff @(posedge CLK) begin
      if (RST) begin
         dec_state <= D_IDLE;
         to_cnt    <= '0;
         vol_q     <= VOL_RST_V;
         jtrack_q  <= '0;
         prev_q    <= 1'b0;
         next_q    <= 1'b0;
         up_q      <= 1'b0;
         down_q    <= 1'b0;
         jump_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         dec_state <= dec_state_n;
         to_cnt    <= to_cnt_n;
         vol_q     <= vol_n;
         jtrack_q  <= jtrack_n;
         prev_q    <= prev_n;
         next_q    <= next_n;
         up_q      <= up_n;
         down_q    <= down_n;
         jump_q    <= jump_n;
         err_q     <= err_n;
      end
   end

   always_comb begin
      dec_state_n = dec_state;
      to_cnt_n    = to_cnt;
      vol_n       = vol_q;
      jtrack_n    = jtrack_q;
      prev_n      = 1'b0;
      next_n      = 1'b0;
      up_n        = 1'b0;
      down_n      = 1'b0;
      jump_n      = 1'b0;
      err_n       = 1'b0;
      case (dec_state)
         D_IDLE: begin
            if (rxd_valid_q) begin
               case (rxd_data_q)
                  8'h55: prev_n = 1'b1;
                  8'h5A: next_n = 1'b1;
                  8'hA5: begin
                     if (vol_q < VOL_MAX_V) begin
                        vol_n = vol_q + VOL_W'(1);
                        up_n  = 1'b1;
                     end else begin
                        err_n = 1'b1;
                     end
                  end
                  8'hAA: begin
                     if (vol_q != '0) begin
                        vol_n  = vol_q - VOL_W'(1);
                        down_n = 1'b1;
                     end else begin
                        err_n = 1'b1;
                     end
                  end
                  8'hC0: begin
                     dec_state_n = D_ARG;
                     to_cnt_n    = '0;
                  end
                  default: begin
                     // 0x91..0x9F carry a one-based track number in the low nibble
                     if (rxd_data_q[7:4] == 4'h9 && rxd_data_q[3:0] != 4'h0 &&
                         rxd_data_q[3:0] <= NTRK) begin
                        jtrack_n = TRACK_W'(rxd_data_q[3:0] - 4'd1);
                        jump_n   = 1'b1;
                     end else begin
                        err_n = 1'b1;
                     end
                  end
               endcase
            end
         end
         D_ARG: begin
            // An argument byte wins over a timeout landing on the same cycle
            if (rxd_valid_q) begin
               vol_n       = (rxd_data_q > VOL_MAX_B) ? VOL_MAX_V : VOL_W'(rxd_data_q);
               dec_state_n = D_IDLE;
            end else if (to_cnt == TO_LAST) begin
               err_n       = 1'b1;
               dec_state_n = D_IDLE;
            end else begin
               to_cnt_n = to_cnt + TO_W'(1);
            end
         end
         default: dec_state_n = D_IDLE;
      endcase
   end

   assign bus.RXD_DATA   = rxd_data_q;
   assign bus.RXD_VALID  = rxd_valid_q;
   assign bus.FRAME_ERR  = frame_err_q;
   assign bus.PREV       = prev_q;
   assign bus.NEXT       = next_q;
   assign bus.UP         = up_q;
   assign bus.DOWN       = down_q;
   assign bus.JUMP       = jump_q;
   assign bus.JUMP_TRACK = jtrack_q;
   assign bus.VOLUME     = vol_q;
   assign bus.CMD_ERR    = err_q;
endmodule

// File: doc/bt_cmd_rx.md
Name: bt_cmd_rx

Overview:
- Parametrised successor to the MP3 player's Bluetooth command path.
- Integrates a 16x-oversampled UART receiver with a byte-framed command decoder.
- Each accepted command produces exactly one single-cycle strobe (transport, volume, track jump). Commands no longer hold levels while a byte value persists.
- Adds absolute track jump with range check, an internal saturating volume register, a two-byte "set volume" command with inter-byte timeout, and error reporting.

Parameters:
- CLK_HZ, 100000000, system clock frequency in Hz
- BAUD, 9600, UART bit rate; oversample tick divider DIV = CLK_HZ/(BAUD*16), integer, DIV >= 2
- NUM_TRACKS, 8, number of playable tracks (1..15)
- TRACK_W, 4, width of track index outputs
- VOL_W, 4, width of volume register
- VOL_MAX, 15, maximum volume (VOL_MAX <= 2^VOL_W-1)
- VOL_RST, 8, volume value after reset
- TIMEOUT_CYC, 1000000, maximum CLK cycles between prefix byte and its argument byte

Ports:
- CLK, input, 1, system clock; all logic on posedge
- RST, input, 1, synchronous active-high reset
- UART_RXD, input, 1, asynchronous serial line from the Bluetooth module; idle high
- RXD_DATA, output, 8, last correctly framed byte
- RXD_VALID, output, 1, one-cycle strobe when RXD_DATA updates
- FRAME_ERR, output, 1, one-cycle strobe when the stop bit is sampled low
- PREV, output, 1, one-cycle strobe: previous track
- NEXT, output, 1, one-cycle strobe: next track
- UP, output, 1, one-cycle strobe: volume was incremented
- DOWN, output, 1, one-cycle strobe: volume was decremented
- JUMP, output, 1, one-cycle strobe: absolute track select
- JUMP_TRACK, output, TRACK_W, zero-based target track; valid when JUMP=1, held otherwise
- VOLUME, output, VOL_W, current volume level
- CMD_ERR, output, 1, one-cycle strobe: unknown byte, out-of-range jump, or prefix timeout

Behaviour:
Reset (RST=1 at posedge):
- All strobes = 0; RXD_DATA = 0; JUMP_TRACK = 0; VOLUME = VOL_RST.
- Receiver and decoder return to IDLE; tick divider clears.
- Reset mid-frame discards the partial byte.

Receiver:
- UART_RXD passes through a 2-flop synchronizer (initialised to 1 on reset).
- Tick divider counts 0..DIV-1 and produces one tick per wrap.
- States:
  - R_IDLE: synchronized line low -> R_START, tick count cleared.
  - R_START: at the 8th tick, line still low -> R_DATA; line high -> R_IDLE (glitch rejected, no error).
  - R_DATA: 8 bits sampled every 16 ticks, LSB first.
  - R_STOP: sampled 16 ticks after the last data bit. High -> RXD_DATA loaded and RXD_VALID pulses the next cycle. Low -> FRAME_ERR pulses, byte dropped.
  - Both R_STOP outcomes return to R_IDLE. If the line is low at that point, R_IDLE starts the next frame (back-to-back frames).

Decoder (acts only on cycles with RXD_VALID=1; strobes assert the cycle after RXD_VALID):
- States D_IDLE and D_ARG.
- In D_IDLE:
  - 0x55 -> PREV.
  - 0x5A -> NEXT.
  - 0xA5 -> if VOLUME < VOL_MAX, VOLUME+1 and UP; else CMD_ERR (saturated).
  - 0xAA -> if VOLUME > 0, VOLUME-1 and DOWN; else CMD_ERR.
  - 0x91..0x9F: n = byte[3:0]. If n <= NUM_TRACKS, JUMP_TRACK = n-1 and JUMP; else CMD_ERR.
  - 0xC0 -> D_ARG, timeout counter cleared, no strobe.
  - Any other byte -> CMD_ERR.
- In D_ARG:
  - Next byte b sets VOLUME = min(b, VOL_MAX), then D_IDLE. UP/DOWN are not asserted. b > VOL_MAX clamps without error.
  - Timeout counter increments every cycle. On reaching TIMEOUT_CYC -> CMD_ERR, D_IDLE.
  - A byte arriving on the same cycle the counter reaches TIMEOUT_CYC is accepted as the argument; no timeout error.
- FRAME_ERR in D_ARG does not change decoder state.
- At most one of PREV/NEXT/UP/DOWN/JUMP/CMD_ERR is high in any cycle.

Test Plan:
- Use CLK_HZ=1600000, BAUD=10000 (DIV=10, 160 cycles/bit).
- Reset, then send 0x55 -> RXD_VALID one pulse, RXD_DATA=0x55, PREV high exactly 1 cycle; VOLUME=8.
- Send 0x94, then 0x99 with NUM_TRACKS=8 -> first gives JUMP with JUMP_TRACK=3; second gives CMD_ERR, JUMP_TRACK stays 3.
- Send 0xA5 x8 from VOLUME=8 -> 7 UP strobes, VOLUME=15, 8th byte gives CMD_ERR. Then 0xC0,0x03 -> VOLUME=3, no UP/DOWN.
- Send 0xC0, idle TIMEOUT_CYC (shrunk to 5000) -> CMD_ERR once; a following 0x5A -> NEXT, not treated as an argument.
- Frame 0x5A with stop bit low -> FRAME_ERR, no RXD_VALID, no NEXT. A 3-tick low glitch on an idle line -> no activity.
- Two back-to-back frames 0x55,0x5A with no idle gap -> PREV then NEXT. Assert RST mid-second frame -> no NEXT, VOLUME=8.
